// File: rtl/apb_cmd_master.sv
// Command-queue APB master: buffers read/write commands in a small FIFO,
// runs each one as an APB SETUP/ACCESS transfer with a wait-state timeout,
// and hands back the result through a single-entry response register.
module apb_cmd_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // Last ACCESS cycle that may still end normally; a low pready here aborts.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_write;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic              full, empty, push, pop, start, done, abort;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  // Refused while full even if the head pops on the same edge.
  assign push      = cmd_valid && !full;
  assign done      = (state == ACCESS) && pready;
  assign abort     = (state == ACCESS) && !pready && (wait_cnt == WAIT_LAST);
  assign pop       = done || abort;
  // Only start when the response slot will be free at completion time.
  assign start     = (state == IDLE) && !empty && (!rsp_valid || rsp_ready);
  // Only registered state feeds busy; no combinational input path.
  assign busy      = !empty || (state != IDLE);

  // Command storage; contents need no reset since count gates their use.
  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
      fifo_write[wr_ptr] <= cmd_write;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FSM state register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and bus strobes from the current state.
  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // APB address/data: loaded from the FIFO head on entry to SETUP, held otherwise.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (start) begin
      paddr  <= fifo_addr[rd_ptr];
      pwrite <= fifo_write[rd_ptr];
      if (fifo_write[rd_ptr]) pwdata <= fifo_wdata[rd_ptr];
    end
  end

  // Wait counter: cleared entering ACCESS, counts ACCESS cycles with pready low.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                        wait_cnt <= '0;
    else if (state == SETUP)           wait_cnt <= '0;
    else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Response slot: a completion overwrites, otherwise a consume clears valid.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (pop) begin
      rsp_valid <= 1'b1;
      rsp_write <= pwrite;
      rsp_err   <= abort;
      rsp_rdata <= (done && !pwrite) ? prdata : '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed command sequences against a reactive
// APB slave, a transaction-level model checked every cycle, and literal
// expectations for the headline timing/data cases.
module tb_apb_cmd_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int TMO = 16;

  logic          pclk, preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Reactive slave: n-th ACCESS cycle answers once n exceeds the wait-state count.
  int          slv_ws    = 0;
  bit          slv_stuck = 0;
  logic [31:0] slv_base  = 32'h0000_00FF;
  initial begin : slave
    int n;
    n = 0;
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(posedge pclk);
      #1;
      if (psel && penable) n++; else n = 0;
      pready = (n > 0) && !slv_stuck && (n > slv_ws);
      prdata = slv_base + paddr;
    end
  end

  // Transaction-level model: a command queue, the cycle index within the
  // current transfer (0 = none, 1 = setup, k+1 = k-th access cycle), and
  // the expected response slot.
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        mq[$];
  int          xfer = 0;
  bit          sv = 0, sw = 0, se = 0;
  logic [31:0] srd = '0;

  always @(negedge pclk) begin : model
    bit   fin, ab, was_full;
    cmd_t c;
    if (preset) begin
      mq.delete();
      xfer = 0;
      sv   = 0;
    end else begin
      chk("psel", psel, xfer > 0);
      chk("penable", penable, xfer > 1);
      chk("cmd_ready", cmd_ready, mq.size() < DEP);
      chk("busy", busy, (mq.size() > 0) || (xfer > 0));
      chk("rsp_valid", rsp_valid, sv);
      if (sv) begin
        chk("rsp_write", rsp_write, sw);
        chk("rsp_err", rsp_err, se);
        chk("rsp_rdata", rsp_rdata, srd);
      end
      if (xfer > 0) begin
        chk("paddr", paddr, mq[0].a);
        chk("pwrite", pwrite, mq[0].w);
        if (mq[0].w) chk("pwdata", pwdata, mq[0].d);
      end
      // Outcome of the coming edge.
      was_full = (mq.size() == DEP);
      fin = (xfer > 1) && pready;
      ab  = (xfer > 1) && !pready && (xfer - 1 == TMO);
      if (sv && rsp_ready) sv = 0;
      if (fin || ab) begin
        sv  = 1;
        sw  = mq[0].w;
        se  = ab;
        srd = (ab || mq[0].w) ? 32'h0 : prdata;
        void'(mq.pop_front());
        xfer = 0;
      end else if (xfer > 0) begin
        xfer++;
      end else if (mq.size() > 0 && !sv) begin
        xfer = 1;
      end
      if (cmd_valid && !was_full) begin
        c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
        mq.push_back(c);
      end
    end
  end

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d);
    int g;
    g = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    if (!cmd_ready) chk("send_wait", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int g;
    g = 0;
    while (!rsp_valid && g < 60) begin tick(); g++; end
    if (!rsp_valid) chk("rsp_wait", 0, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin : stim
    int ps, pe, rat, g;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    preset = 1'b0;
    tick();
    chk("rst_psel", psel, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    // Zero-wait write.
    send(1'b1, 32'h04, 32'hA5A5_0001);
    ps = 0; pe = 0; rat = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (psel) ps++;
      if (penable) pe++;
      if (psel && penable) chk("wr_pwdata", pwdata, 32'hA5A5_0001);
      if (rsp_valid && rat < 0) rat = i;
    end
    chk("wr_psel_cycles", ps, 2);
    chk("wr_penable_cycles", pe, 1);
    chk("wr_rsp_cycle", rat, 2);
    chk("wr_rsp_write", rsp_write, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    consume();

    // Read with two wait states.
    slv_ws = 2;
    send(1'b0, 32'h00, 32'h0);
    pe = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (penable) pe++;
      if (psel) chk("rd_paddr", paddr, 32'h0);
    end
    chk("rd_access_cycles", pe, 3);
    chk("rd_rsp_rdata", rsp_rdata, 32'h0000_00FF);
    chk("rd_rsp_err", rsp_err, 0);
    consume();
    slv_ws = 0;

    // Stuck slave: timeout abort.
    slv_stuck = 1;
    send(1'b0, 32'h08, 32'h0);
    pe = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (penable) pe++;
    end
    chk("to_access_cycles", pe, TMO);
    chk("to_psel", psel, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    consume();

    // Fill the FIFO behind a stuck transfer with responses blocked.
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_addr = 32'h40 + 32'(4 * i); cmd_wdata = 32'h100 + 32'(i);
      tick();
    end
    chk("full_cmd_ready", cmd_ready, 0);
    cmd_addr = 32'h50; cmd_wdata = 32'h555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      chk("full_rsp_err", rsp_err, 1);
      consume();
    end
    repeat (2) tick();
    chk("full_drained_busy", busy, 0);
    slv_stuck = 0;

    // Two reads queued while the response slot is blocked.
    send(1'b0, 32'h10, 32'h0);
    send(1'b0, 32'h20, 32'h0);
    wait_rsp();
    chk("q_rsp1_rdata", rsp_rdata, 32'h0000_010F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("q_hold_psel", psel, 0);
    end
    consume();
    wait_rsp();
    chk("q_rsp2_rdata", rsp_rdata, 32'h0000_011F);
    chk("q_rsp2_write", rsp_write, 0);
    consume();

    // Reset in the middle of ACCESS.
    slv_stuck = 1;
    send(1'b0, 32'h30, 32'h0);
    g = 0;
    while (!penable && g < 10) begin tick(); g++; end
    chk("mid_reached_access", penable, 1);
    #2 preset = 1'b1;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    tick();
    preset = 1'b0;
    slv_stuck = 0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_rsp_valid", rsp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
